// File: rtl/fft_pkg.sv
// Shared definitions for the 4-lane SSR FFT core and its output collector.
package fft_pkg;

  localparam int FFT_SSR       = 4;
  localparam int FFT_OUT_W     = 42;
  localparam int FFT_FRAME_LEN = 1024;

  typedef logic [FFT_SSR-1:0][FFT_OUT_W-1:0] fft_vec_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_LOAD,
    RD_STREAM
  } rd_state_e;

endpackage

// File: rtl/fft_out_collector_if.sv
// Single-lane valid/ready sample stream leaving the FFT output collector.
interface fft_out_collector_if #(
  parameter int DATA_W = 42
);
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);
endinterface

// File: rtl/fft_pingpong_ram.sv
// Simple dual-port ping-pong frame store with registered read; maps onto block RAM.
module fft_pingpong_ram #(
  parameter int WIDTH  = 168,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_W];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/fft_out_collector.sv
// Collects 4-lane FFT output vectors into a ping-pong buffer and replays each frame as a 1-lane stream.
module fft_out_collector
  import fft_pkg::*;
#(
  parameter int DATA_W    = FFT_OUT_W,
  parameter int FRAME_LEN = FFT_FRAME_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] outData_0,
  input  logic [DATA_W-1:0] outData_1,
  input  logic [DATA_W-1:0] outData_2,
  input  logic [DATA_W-1:0] outData_3,
  input  logic              outData_0_we,
  input  logic              outData_1_we,
  input  logic              outData_2_we,
  input  logic              outData_3_we,
  input  logic              flush,
  fft_out_collector_if.master m_if,
  output logic [1:0]        bank_full,
  output logic              overflow,
  output logic              lane_err,
  input  logic              clr_err,
  output logic [15:0]       frames_out
);

  localparam int VEC_PER_FRAME = FRAME_LEN / FFT_SSR;
  localparam int VEC_W         = (VEC_PER_FRAME > 1) ? $clog2(VEC_PER_FRAME) : 1;
  localparam int ADDR_W        = VEC_W + 1;
  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(VEC_PER_FRAME - 1);

  rd_state_e         state_q, state_d;
  logic [VEC_W-1:0]  wr_idx_q, wr_idx_d, rd_vec_q, rd_vec_d;
  logic              wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d;
  logic [1:0]        lane_q, lane_d, bank_full_q, bank_full_d;
  logic              overflow_q, overflow_d, lane_err_q, lane_err_d;
  logic [15:0]       frames_q, frames_d;

  logic                          ram_we, ram_re, lane_mis, wr_drop;
  logic [FFT_SSR-1:0][DATA_W-1:0] wr_vec, rd_vec;

  assign wr_vec   = {outData_3, outData_2, outData_1, outData_0};
  assign lane_mis = (outData_1_we != outData_0_we) | (outData_2_we != outData_0_we) |
                    (outData_3_we != outData_0_we);
  assign wr_drop  = outData_0_we & bank_full_q[wr_bank_q];
  assign ram_we   = outData_0_we & ~bank_full_q[wr_bank_q] & ~flush;

  fft_pingpong_ram #(
    .WIDTH  (FFT_SSR * DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr ({wr_bank_q, wr_idx_q}),
    .wdata (wr_vec),
    .re    (ram_re),
    .raddr ({rd_bank_q, rd_vec_q}),
    .rdata (rd_vec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RD_IDLE;
      wr_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_vec_q    <= '0;
      rd_bank_q   <= 1'b0;
      lane_q      <= '0;
      bank_full_q <= '0;
      overflow_q  <= 1'b0;
      lane_err_q  <= 1'b0;
      frames_q    <= '0;
    end else begin
      state_q     <= state_d;
      wr_idx_q    <= wr_idx_d;
      wr_bank_q   <= wr_bank_d;
      rd_vec_q    <= rd_vec_d;
      rd_bank_q   <= rd_bank_d;
      lane_q      <= lane_d;
      bank_full_q <= bank_full_d;
      overflow_q  <= overflow_d;
      lane_err_q  <= lane_err_d;
      frames_q    <= frames_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    wr_idx_d    = wr_idx_q;
    wr_bank_d   = wr_bank_q;
    rd_vec_d    = rd_vec_q;
    rd_bank_d   = rd_bank_q;
    lane_d      = lane_q;
    bank_full_d = bank_full_q;
    frames_d    = frames_q;
    ram_re      = 1'b0;

    unique case (state_q)
      RD_IDLE: if (bank_full_q[rd_bank_q]) state_d = RD_LOAD;
      RD_LOAD: begin
        ram_re  = 1'b1;
        lane_d  = '0;
        state_d = RD_STREAM;
      end
      RD_STREAM: begin
        if (m_if.m_ready) begin
          if (lane_q != 2'd3) begin
            lane_d = lane_q + 2'd1;
          end else if (rd_vec_q != VEC_LAST) begin
            rd_vec_d = rd_vec_q + 1'b1;
            state_d  = RD_LOAD;
          end else begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d = ~rd_bank_q;
            rd_vec_d  = '0;
            frames_d  = frames_q + 16'd1;
            state_d   = RD_IDLE;
          end
        end
      end
      default: state_d = RD_IDLE;
    endcase

    // A write can never complete the bank being cleared: writes into a full bank are dropped.
    if (ram_we) begin
      if (wr_idx_q == VEC_LAST) begin
        bank_full_d[wr_bank_q] = 1'b1;
        wr_idx_d  = '0;
        wr_bank_d = ~wr_bank_q;
      end else begin
        wr_idx_d = wr_idx_q + 1'b1;
      end
    end

    if (flush) begin
      state_d     = RD_IDLE;
      wr_idx_d    = '0;
      wr_bank_d   = 1'b0;
      rd_vec_d    = '0;
      rd_bank_d   = 1'b0;
      lane_d      = '0;
      bank_full_d = '0;
    end

    overflow_d = (clr_err ? 1'b0 : overflow_q) | wr_drop;
    lane_err_d = (clr_err ? 1'b0 : lane_err_q) | lane_mis;
  end

  always_comb begin
    m_if.m_valid = (state_q == RD_STREAM);
    m_if.m_data  = m_if.m_valid ? rd_vec[lane_q] : '0;
    m_if.m_last  = m_if.m_valid && (lane_q == 2'd3) && (rd_vec_q == VEC_LAST);
  end

  assign bank_full  = bank_full_q;
  assign overflow   = overflow_q;
  assign lane_err   = lane_err_q;
  assign frames_out = frames_q;

endmodule

// File: tb/tb_fft_out_collector.sv
// Directed self-checking bench for fft_out_collector with a 16-point frame.
module tb_fft_out_collector;

  localparam int DW = 42;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] d0 = '0, d1 = '0, d2 = '0, d3 = '0;
  logic          we0 = 1'b0, we1 = 1'b0, we2 = 1'b0, we3 = 1'b0;
  logic          flush = 1'b0, clr_err = 1'b0;
  logic [1:0]    bank_full;
  logic          overflow, lane_err;
  logic [15:0]   frames_out;

  int vectors = 0;
  int miscompares = 0;
  int exp_frames = 0;

  fft_out_collector_if #(.DATA_W(DW)) s ();

  fft_out_collector #(.DATA_W(DW), .FRAME_LEN(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .outData_0(d0), .outData_1(d1), .outData_2(d2), .outData_3(d3),
    .outData_0_we(we0), .outData_1_we(we1), .outData_2_we(we2), .outData_3_we(we3),
    .flush(flush), .m_if(s.master),
    .bank_full(bank_full), .overflow(overflow), .lane_err(lane_err),
    .clr_err(clr_err), .frames_out(frames_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_vec(input int base, input logic [3:0] we, input logic clr);
    d0 = DW'(base); d1 = DW'(base + 1); d2 = DW'(base + 2); d3 = DW'(base + 3);
    {we3, we2, we1, we0} = we;
    clr_err = clr;
    step();
    {we3, we2, we1, we0} = 4'b0000;
    clr_err = 1'b0;
  endtask

  task automatic write_frame(input int base);
    for (int v = 0; v < 4; v++) write_vec(base + 4 * v, 4'b1111, 1'b0);
  endtask

  // mode 0: always ready; mode 1: alternating ready with 3-cycle stalls
  task automatic drain(input int n, input int first, input int mode);
    int beats = 0;
    int cyc = 0;
    logic held = 1'b0;
    logic [DW-1:0] hd = '0;
    logic hl = 1'b0;
    logic rdy;
    while (beats < n && cyc < 600) begin
      if (mode == 0) rdy = 1'b1;
      else rdy = ((cyc % 11) inside {4, 5, 6}) ? 1'b0 : (cyc % 2 == 1);
      s.m_ready = rdy;
      if (held) begin
        check("stall_valid", s.m_valid, 1);
        check("stall_data", s.m_data, hd);
        check("stall_last", s.m_last, hl);
      end
      held = s.m_valid && !rdy;
      hd = s.m_data;
      hl = s.m_last;
      if (s.m_valid && rdy) begin
        check("data", s.m_data, first + beats);
        check("last", s.m_last, (beats % 16) == 15);
        beats++;
      end
      step();
      cyc++;
    end
    if (beats < n) check("drain_timeout", beats, n);
    s.m_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    s.m_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
    check("rst_valid", s.m_valid, 0);
    check("rst_data", s.m_data, 0);
    check("rst_last", s.m_last, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_frames", frames_out, 0);
    check("rst_overflow", overflow, 0);
    check("rst_lane_err", lane_err, 0);

    // single frame, latency then stream
    write_frame(0);
    check("t1_bank_full", bank_full, 2'b01);
    check("t1_valid_early", s.m_valid, 0);
    lat = 0;
    while (!s.m_valid && lat < 10) begin
      step();
      lat++;
    end
    check("t1_latency", lat, 2);
    drain(16, 0, 0);
    exp_frames++;
    check("t1_frames", frames_out, exp_frames);
    check("t1_bank_full_end", bank_full, 0);

    // two back-to-back frames drained concurrently
    fork
      begin write_frame(0); write_frame(16); end
      drain(32, 0, 0);
    join
    exp_frames += 2;
    check("t2_overflow", overflow, 0);
    check("t2_frames", frames_out, exp_frames);
    check("t2_bank_full", bank_full, 0);

    // backpressure with stalls
    write_frame(0);
    drain(16, 0, 1);
    exp_frames++;
    check("t3_frames", frames_out, exp_frames);

    // three frames with no drain: the third is dropped
    write_frame(0);
    write_frame(16);
    write_frame(32);
    check("t4_bank_full", bank_full, 2'b11);
    check("t4_overflow", overflow, 1);
    drain(32, 0, 0);
    exp_frames += 2;
    for (int i = 0; i < 10; i++) step();
    check("t4_no_extra", s.m_valid, 0);
    check("t4_bank_full_end", bank_full, 0);
    check("t4_frames", frames_out, exp_frames);
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t4_overflow_clr", overflow, 0);

    // lane strobe disagreement, coinciding with clr_err (set wins)
    write_vec(64, 4'b1111, 1'b0);
    write_vec(68, 4'b1011, 1'b1);
    write_vec(72, 4'b1111, 1'b0);
    write_vec(76, 4'b1111, 1'b0);
    check("t5_lane_err", lane_err, 1);
    drain(16, 64, 0);
    exp_frames++;
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    check("t5_lane_err_clr", lane_err, 0);
    check("t5_frames", frames_out, exp_frames);

    // flush discards a partial frame and realigns the write pointer
    write_vec(500, 4'b1111, 1'b0);
    write_vec(504, 4'b1111, 1'b0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t6_bank_full", bank_full, 0);
    write_frame(80);
    drain(16, 80, 0);
    exp_frames++;
    check("t6_frames", frames_out, exp_frames);

    // asynchronous reset mid-stream
    write_frame(0);
    drain(7, 0, 0);
    check("t7_valid_pre", s.m_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t7_valid", s.m_valid, 0);
    check("t7_data", s.m_data, 0);
    check("t7_last", s.m_last, 0);
    check("t7_bank_full", bank_full, 0);
    check("t7_frames", frames_out, 0);
    step();
    rst_n = 1'b1;
    exp_frames = 0;
    write_frame(200);
    drain(16, 200, 0);
    exp_frames++;
    check("t7_frames_after", frames_out, exp_frames);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
